// File: rtl/mmult_pkg.sv
// Shared definitions for the matrix-multiply sequencer: state encoding,
// default geometry and the expected cycle count of one job.
package mmult_pkg;

    localparam int N_DEFAULT  = 4;
    localparam int AW_DEFAULT = 14;
    localparam int DW_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        MAC  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5
    } state_t;

    // Cycles from the first RD_A cycle to the DONE cycle when the memory
    // grants every request immediately: N*N elements of 3N+1 cycles each.
    function automatic int unsigned mmult_cycles(input int unsigned n);
        return n * n * (3 * n + 1);
    endfunction

endpackage

// File: rtl/mmult_index_ctr.sv
// Nested i/j/k loop counters for the sequencer plus the three running
// address pointers. Addresses are produced by incremental adds only, so no
// multiplier sits on the address path; all pointer arithmetic wraps at 2^AW.
module mmult_index_ctr
    import mmult_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          step_k,
    input  logic          step_ij,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    input  logic [AW-1:0] s_base,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic [AW-1:0] s_addr,
    output logic          k_last,
    output logic          elem_last
);

    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST     = CW'(N - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(N);

    logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    // a_row: A address of element (i,0); b_col: B address of element (0,j)
    logic [AW-1:0] a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d, s_ptr_q, s_ptr_d;
    logic [AW-1:0] a_row_q, a_row_d, b_col_q, b_col_d, b_base_q, b_base_d;

    // Counter and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_ptr_q  <= '0;
            b_ptr_q  <= '0;
            s_ptr_q  <= '0;
            a_row_q  <= '0;
            b_col_q  <= '0;
            b_base_q <= '0;
        end else begin
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            a_ptr_q  <= a_ptr_d;
            b_ptr_q  <= b_ptr_d;
            s_ptr_q  <= s_ptr_d;
            a_row_q  <= a_row_d;
            b_col_q  <= b_col_d;
            b_base_q <= b_base_d;
        end
    end

    // Next-state: clear loads the bases, step_k walks along k, step_ij
    // moves to the next output element (j inner, i outer).
    always_comb begin
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        a_ptr_d  = a_ptr_q;
        b_ptr_d  = b_ptr_q;
        s_ptr_d  = s_ptr_q;
        a_row_d  = a_row_q;
        b_col_d  = b_col_q;
        b_base_d = b_base_q;
        if (clear) begin
            i_d      = '0;
            j_d      = '0;
            k_d      = '0;
            a_ptr_d  = a_base;
            b_ptr_d  = b_base;
            s_ptr_d  = s_base;
            a_row_d  = a_base;
            b_col_d  = b_base;
            b_base_d = b_base;
        end else if (step_ij) begin
            k_d     = '0;
            s_ptr_d = s_ptr_q + AW'(1);
            if (j_q == LAST) begin
                j_d     = '0;
                i_d     = (i_q == LAST) ? '0 : i_q + CW'(1);
                a_row_d = a_row_q + ROW_STEP;
                a_ptr_d = a_row_q + ROW_STEP;
                b_col_d = b_base_q;
                b_ptr_d = b_base_q;
            end else begin
                j_d     = j_q + CW'(1);
                a_ptr_d = a_row_q;
                b_col_d = b_col_q + AW'(1);
                b_ptr_d = b_col_q + AW'(1);
            end
        end else if (step_k) begin
            k_d     = k_q + CW'(1);
            a_ptr_d = a_ptr_q + AW'(1);
            b_ptr_d = b_ptr_q + ROW_STEP;
        end
    end

    assign a_addr    = a_ptr_q;
    assign b_addr    = b_ptr_q;
    assign s_addr    = s_ptr_q;
    assign k_last    = (k_q == LAST);
    assign elem_last = (i_q == LAST) && (j_q == LAST);

endmodule

// File: rtl/mmult_sequencer.sv
// Matrix-multiply sequencer: S = A x B for NxN matrices in data memory,
// using one word-wide request/grant memory port. All outputs are decoded
// from registered state, so mem_gnt never reaches an output combinationally.
module mmult_sequencer
    import mmult_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    input  logic [AW-1:0] s_base,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state_q, state_d;
    logic [DW-1:0] a_reg_q, a_reg_d;
    logic [DW-1:0] acc_q, acc_d;
    // Marks the first RD_B cycle, the only one in which the A word is valid.
    logic          rdb_first_q, rdb_first_d;

    logic          idx_clear, idx_step_k, idx_step_ij;
    logic [AW-1:0] a_addr, b_addr, s_addr;
    logic          k_last, elem_last;

    mmult_index_ctr #(
        .N  (N),
        .AW (AW)
    ) u_index_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear     (idx_clear),
        .step_k    (idx_step_k),
        .step_ij   (idx_step_ij),
        .a_base    (a_base),
        .b_base    (b_base),
        .s_base    (s_base),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .s_addr    (s_addr),
        .k_last    (k_last),
        .elem_last (elem_last)
    );

    // State, operand and accumulator registers; reset discards any partial sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_reg_q     <= '0;
            acc_q       <= '0;
            rdb_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_reg_q     <= a_reg_d;
            acc_q       <= acc_d;
            rdb_first_q <= rdb_first_d;
        end
    end

    // Next-state logic and counter strobes.
    always_comb begin
        state_d     = state_q;
        a_reg_d     = a_reg_q;
        acc_d       = acc_q;
        rdb_first_d = 1'b0;
        idx_clear   = 1'b0;
        idx_step_k  = 1'b0;
        idx_step_ij = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    idx_clear = 1'b1;
                    acc_d     = '0;
                    state_d   = RD_A;
                end
            end
            RD_A: begin
                if (mem_gnt) begin
                    rdb_first_d = 1'b1;
                    state_d     = RD_B;
                end
            end
            RD_B: begin
                if (rdb_first_q) begin
                    a_reg_d = mem_rdata;
                end
                if (mem_gnt) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                // Low DW bits of the product; the sum wraps mod 2^DW.
                acc_d = acc_q + a_reg_q * mem_rdata;
                if (k_last) begin
                    state_d = WR;
                end else begin
                    idx_step_k = 1'b1;
                    state_d    = RD_A;
                end
            end
            WR: begin
                if (mem_gnt) begin
                    acc_d       = '0;
                    idx_step_ij = 1'b1;
                    state_d     = elem_last ? DONE : RD_A;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory port decode; request fields only depend on registered values,
    // so they hold steady while a request waits for its grant.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            RD_A: begin
                mem_req  = 1'b1;
                mem_addr = a_addr;
            end
            RD_B: begin
                mem_req  = 1'b1;
                mem_addr = b_addr;
            end
            WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = s_addr;
                mem_wdata = acc_q;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_mmult_sequencer.sv
// Self-checking bench for mmult_sequencer. A behavioural model expands each
// job into the ordered list of memory transactions (A read, B read per k,
// then the S write with the plain-arithmetic dot product); a memory
// responder process checks every granted transaction against that list.
module tb_mmult_sequencer;
    import mmult_pkg::*;

    localparam int N  = 4;
    localparam int AW = 14;
    localparam int DW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] a_base = '0, b_base = '0, s_base = '0;
    logic          busy, done, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    txn_t          exp_q[$];

    int tests = 0, fails = 0;
    int cyc = 0, stall_mode = 0;
    int writes_seen = 0, done_seen = 0, stall_cnt = 0;
    int first_req_cyc = -1, done_cyc = -1, last_latency = 0;

    mmult_sequencer #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_base    (a_base),
        .b_base    (b_base),
        .s_base    (s_base),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Expected transaction stream of one job, from the matrix definition.
    task automatic build_model(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                               input logic [AW-1:0] sb);
        logic [DW-1:0] acc;
        logic [AW-1:0] aa, ba;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int k = 0; k < N; k++) begin
                    aa = ab + AW'(i * N + k);
                    ba = bb + AW'(k * N + j);
                    exp_q.push_back('{1'b0, aa, {DW{1'b0}}});
                    exp_q.push_back('{1'b0, ba, {DW{1'b0}}});
                    acc = acc + mem[aa] * mem[ba];
                end
                exp_q.push_back('{1'b1, sb + AW'(i * N + j), acc});
            end
        end
    endtask

    // Memory responder and per-cycle checker, running on the falling edge.
    initial begin
        logic                  rd_pend;
        logic [AW-1:0]         rd_addr;
        logic                  prev_stalled, prev_rst;
        logic [AW+DW+1:0]      prev_vec;
        txn_t                  e;
        rd_pend      = 1'b0;
        rd_addr      = '0;
        prev_stalled = 1'b0;
        prev_rst     = 1'b1;
        prev_vec     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_stalled && !prev_rst)
                chk("stall_stable", {mem_req, mem_we, mem_addr, mem_wdata}, prev_vec);
            mem_rdata = rd_pend ? mem[rd_addr] : DW'($urandom);
            rd_pend   = 1'b0;
            mem_gnt   = (stall_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (mem_req && mem_gnt) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_txn: actual we=%0d addr=0x%0h required=no request",
                             mem_we, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("txn_we", 64'(mem_we), 64'(e.we));
                    chk("txn_addr", 64'(mem_addr), 64'(e.addr));
                    if (e.we)
                        chk("txn_wdata", 64'(mem_wdata), 64'(e.data));
                end
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    writes_seen++;
                    $display("[TB] write addr=0x%04h data=0x%08h", mem_addr, mem_wdata);
                end else begin
                    rd_pend = 1'b1;
                    rd_addr = mem_addr;
                end
            end
            if (mem_req && !mem_gnt) stall_cnt++;
            if (mem_req && first_req_cyc < 0) first_req_cyc = cyc;
            if (done) begin
                done_seen++;
                done_cyc = cyc;
            end
            prev_stalled = mem_req && !mem_gnt;
            prev_rst     = rst;
            prev_vec     = {mem_req, mem_we, mem_addr, mem_wdata};
        end
    end

    // One job: optional extra start pulses while busy and optional reset.
    task automatic run_job(input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                           input logic [AW-1:0] sb, input int mode,
                           input bit extra, input int rst_at);
        int n;
        int w_before;
        bit aborted;
        build_model(ab, bb, sb);
        stall_mode    = mode;
        first_req_cyc = -1;
        done_cyc      = -1;
        stall_cnt     = 0;
        done_seen     = 0;
        writes_seen   = 0;
        aborted       = 0;
        @(negedge clk);
        a_base = ab;
        b_base = bb;
        s_base = sb;
        start  = 1'b1;
        n      = 0;
        while (done_seen == 0 && n < 4000) begin
            @(negedge clk);
            n++;
            start = extra && (n == 5 || n == 50 || n == 207 || n == 209);
            if (n == 1) chk("busy_after_start", 64'(busy), 64'd1);
            if (rst_at > 0 && n == rst_at) rst = 1'b1;
            if (rst_at > 0 && n == rst_at + 1) begin
                rst = 1'b0;
                chk("rst_req_low", 64'(mem_req), 64'd0);
                chk("rst_busy_low", 64'(busy), 64'd0);
                exp_q.delete();
                aborted = 1;
                break;
            end
        end
        if (aborted) begin
            w_before = writes_seen;
            repeat (300) @(negedge clk);
            chk("no_write_after_rst", 64'(writes_seen), 64'(w_before));
            chk("no_done_after_rst", 64'(done_seen), 64'd0);
            $display("[TB] job aborted by reset, writes before reset=%0d", w_before);
        end else begin
            if (done_seen == 0) begin
                tests++;
                fails++;
                $display("FAIL done_timeout: actual=no done required=done within 4000 cycles");
            end
            @(negedge clk);
            start = 1'b0;
            repeat (3) @(negedge clk);
            last_latency = done_cyc - first_req_cyc;
            chk("busy_after_done", 64'(busy), 64'd0);
            chk("done_count", 64'(done_seen), 64'd1);
            chk("write_count", 64'(writes_seen), 64'(N * N));
            chk("model_drained", 64'(exp_q.size()), 64'd0);
            chk("latency", 64'(last_latency), 64'(mmult_cycles(N) + stall_cnt));
            $display("[TB] job a=0x%04h b=0x%04h s=0x%04h stalls=%0d latency=%0d",
                     ab, bb, sb, stall_cnt, last_latency);
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;

        // Identity x B[i][j]=j, grant always high.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                mem[32'h234 + i * N + j] = (i == j) ? 32'd1 : 32'd0;
                mem[32'h254 + i * N + j] = j;
            end
        end
        run_job(14'h234, 14'h254, 14'h244, 0, 0, -1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk("s_identity", 64'(mem[32'h244 + i * N + j]), 64'(j));
        chk("latency_208", 64'(last_latency), 64'd208);

        // Same data with a randomly stalling grant.
        for (int x = 0; x < N * N; x++) mem[32'h244 + x] = '0;
        run_job(14'h234, 14'h254, 14'h244, 1, 0, -1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk("s_identity_stall", 64'(mem[32'h244 + i * N + j]), 64'(j));

        // All-ones times all-one: sum of four 0xFFFFFFFF wraps.
        for (int x = 0; x < N * N; x++) begin
            mem[32'h300 + x] = 32'hFFFF_FFFF;
            mem[32'h320 + x] = 32'd1;
        end
        run_job(14'h300, 14'h320, 14'h340, 0, 0, -1);
        for (int x = 0; x < N * N; x++)
            chk("s_wrap_data", 64'(mem[32'h340 + x]), 64'hFFFF_FFFC);

        // Start pulses while busy (and during DONE) are ignored.
        run_job(14'h234, 14'h254, 14'h360, 0, 1, -1);

        // Reset mid-operation, then a normal job.
        run_job(14'h234, 14'h254, 14'h380, 0, 0, 60);
        run_job(14'h234, 14'h254, 14'h3A0, 1, 0, -1);
        chk("s_after_rst_0_3", 64'(mem[32'h3A0 + 3]), 64'd3);
        chk("s_after_rst_3_2", 64'(mem[32'h3A0 + 14]), 64'd2);

        // A base near the top of the address space wraps through 0.
        for (int x = 0; x < N * N; x++) begin
            mem[(1 << AW) - 8 + x - ((x >= 8) ? (1 << AW) : 0)] = $urandom;
            mem[32'h100 + x] = $urandom;
        end
        run_job(AW'((1 << AW) - 8), 14'h100, 14'h200, 1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
